hdbn_encoder: RTL and testbench

HDBN_ENCODER -- requirements
Module: hdbn_encoder

---
 rtl/hdbn_pkg.sv | 12 +
 rtl/hdbn_polarity.sv | 56 +++++
 rtl/hdbn_encoder.sv | 101 ++++++++++
 tb/tb_hdbn_encoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdbn_pkg.sv
// Shared symbol codes and default parameters for the HDBn line encoder.
package hdbn_pkg;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_V    = 2'b10;
    localparam logic [1:0] SYM_B    = 2'b11;

    localparam int unsigned ZRUN_DEFAULT  = 4;
    localparam int unsigned RDS_W_DEFAULT = 4;

endpackage

// File: rtl/hdbn_polarity.sv
// Maps substituted symbols onto the two pulse rails and tracks the
// saturating running digital sum.
module hdbn_polarity
    import hdbn_pkg::*;
#(
    parameter int unsigned RDS_W = RDS_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [1:0]       sym,
    output logic [1:0]       sym_out,
    output logic             pos_out,
    output logic             neg_out,
    output logic             out_valid,
    output logic [RDS_W-1:0] rds_out
);

    localparam logic [RDS_W-1:0] RDS_MAX = {1'b0, {(RDS_W-1){1'b1}}};
    localparam logic [RDS_W-1:0] RDS_MIN = ~RDS_MAX + RDS_W'(1);

    logic last_pol_q;   // 1 = last pulse was positive
    logic mark;
    logic pol;

    // V repeats the previous polarity; marks and B alternate it.
    always_comb begin
        mark = (sym != SYM_ZERO);
        pol  = (sym == SYM_V) ? last_pol_q : ~last_pol_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_pol_q <= 1'b0;
            sym_out    <= SYM_ZERO;
            pos_out    <= 1'b0;
            neg_out    <= 1'b0;
            out_valid  <= 1'b0;
            rds_out    <= '0;
        end else begin
            out_valid <= valid;
            sym_out   <= valid ? sym : SYM_ZERO;
            pos_out   <= valid && mark && pol;
            neg_out   <= valid && mark && !pol;
            if (valid && mark) begin
                last_pol_q <= pol;
                if (pol && (rds_out != RDS_MAX)) begin
                    rds_out <= rds_out + RDS_W'(1);
                end else if (!pol && (rds_out != RDS_MIN)) begin
                    rds_out <= rds_out - RDS_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/hdbn_encoder.sv
// HDBn / AMI line encoder: zero-run substitution window followed by the
// polarity stage.
module hdbn_encoder
    import hdbn_pkg::*;
#(
    parameter int unsigned ZRUN  = ZRUN_DEFAULT,
    parameter int unsigned RDS_W = RDS_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             mode_ami,
    output logic [1:0]       sym_out,
    output logic             pos_out,
    output logic             neg_out,
    output logic             out_valid,
    output logic [RDS_W-1:0] rds_out
);

    localparam int unsigned CW = $clog2(ZRUN + 1);

    logic [ZRUN-1:0][1:0] line_q;   // [0] newest, [ZRUN-1] oldest
    logic [ZRUN-1:0][1:0] line_d;
    logic [CW-1:0]        fill_q;
    logic [CW-1:0]        zcnt_q;
    logic                 parity_q;
    logic                 first_v_q;
    logic                 mode_q;
    logic                 full;
    logic                 ami_eff;
    logic                 hit_v;
    logic [1:0]           new_sym;

    // While the window is empty the mode input is live, so the first bit
    // after reset already uses the mode being captured.
    always_comb begin
        full    = (fill_q == CW'(ZRUN));
        ami_eff = (fill_q == '0) ? mode_ami : mode_q;
        hit_v   = !ami_eff && !data_in && (zcnt_q == CW'(ZRUN - 1));
        new_sym = SYM_ZERO;
        if (data_in) begin
            new_sym = SYM_ONE;
        end else if (hit_v) begin
            new_sym = SYM_V;
        end
        line_d = {line_q[ZRUN-2:0], new_sym};
        // The run's first zero sits in the oldest slot after this shift.
        if (hit_v) begin
            line_d[ZRUN-1] = (first_v_q && !parity_q) ? SYM_B : SYM_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_q    <= '0;
            fill_q    <= '0;
            zcnt_q    <= '0;
            parity_q  <= 1'b0;
            first_v_q <= 1'b0;
            mode_q    <= mode_ami;
        end else begin
            if (fill_q == '0) begin
                mode_q <= mode_ami;
            end
            if (data_valid) begin
                line_q <= line_d;
                if (!full) begin
                    fill_q <= fill_q + CW'(1);
                end
                if (data_in) begin
                    zcnt_q   <= '0;
                    parity_q <= ~parity_q;
                end else if (hit_v) begin
                    zcnt_q    <= '0;
                    parity_q  <= 1'b0;
                    first_v_q <= 1'b1;
                end else if (ami_eff) begin
                    zcnt_q <= '0;
                end else begin
                    zcnt_q <= zcnt_q + CW'(1);
                end
            end
        end
    end

    hdbn_polarity #(
        .RDS_W(RDS_W)
    ) u_polarity (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid    (data_valid && full),
        .sym      (line_q[ZRUN-1]),
        .sym_out  (sym_out),
        .pos_out  (pos_out),
        .neg_out  (neg_out),
        .out_valid(out_valid),
        .rds_out  (rds_out)
    );

endmodule

// File: tb/tb_hdbn_encoder.sv
// Scoreboard bench for hdbn_encoder: a ZRUN=4 instance plus a ZRUN=3,
// RDS_W=2 instance sharing the same stimulus.
module tb_hdbn_encoder;

    localparam int ZR = 4;

    typedef struct {
        logic [1:0] sym;
        logic       pos;
        logic       neg;
        int         rds;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       data_in = 1'b0;
    logic       data_valid = 1'b0;
    logic       mode_ami = 1'b0;

    logic [1:0] sym_out;
    logic       pos_out;
    logic       neg_out;
    logic       out_valid;
    logic [3:0] rds_out;

    logic [1:0] sym3;
    logic       pos3;
    logic       neg3;
    logic       ov3;
    logic [1:0] rds3;

    exp_t q[$];
    exp_t q3[$];
    int   checks = 0;
    int   failures = 0;
    int   n_acc = 0;
    logic exp_ov = 1'b0;
    bit   mon_en = 1'b0;
    bit   mon3_en = 1'b0;
    int   last_rds = 0;

    hdbn_encoder #(.ZRUN(4), .RDS_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .mode_ami(mode_ami), .sym_out(sym_out), .pos_out(pos_out), .neg_out(neg_out),
        .out_valid(out_valid), .rds_out(rds_out)
    );

    hdbn_encoder #(.ZRUN(3), .RDS_W(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .mode_ami(mode_ami), .sym_out(sym3), .pos_out(pos3), .neg_out(neg3),
        .out_valid(ov3), .rds_out(rds3)
    );

    always #5 clk = ~clk;

    // out_valid follows every accepted bit once ZR bits are already buffered.
    always @(posedge clk) begin
        if (!reset_n) begin
            n_acc  <= 0;
            exp_ov <= 1'b0;
        end else begin
            exp_ov <= data_valid && (n_acc >= ZR);
            if (data_valid) n_acc <= n_acc + 1;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (out_valid !== exp_ov) begin
                    failures++;
                    $display("FAIL out_valid_timing: got %b expected %b at %0t", out_valid, exp_ov, $time);
                end
                if (out_valid === 1'b1) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        checks++;
                        if (sym_out !== e.sym || pos_out !== e.pos || neg_out !== e.neg ||
                            $signed(rds_out) !== e.rds) begin
                            failures++;
                            $display("FAIL symbol: got sym=%b pos=%b neg=%b rds=%0d expected sym=%b pos=%b neg=%b rds=%0d at %0t",
                                     sym_out, pos_out, neg_out, $signed(rds_out), e.sym, e.pos, e.neg, e.rds, $time);
                        end
                    end
                end else begin
                    checks++;
                    if (sym_out !== 2'b00 || pos_out !== 1'b0 || neg_out !== 1'b0 ||
                        $signed(rds_out) !== last_rds) begin
                        failures++;
                        $display("FAIL idle_outputs: got sym=%b pos=%b neg=%b rds=%0d expected 00 0 0 rds=%0d at %0t",
                                 sym_out, pos_out, neg_out, $signed(rds_out), last_rds, $time);
                    end
                end
                last_rds = $signed(rds_out);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon3_en && ov3 === 1'b1 && q3.size() > 0) begin
                e = q3.pop_front();
                checks++;
                if (sym3 !== e.sym || pos3 !== e.pos || neg3 !== e.neg || $signed(rds3) !== e.rds) begin
                    failures++;
                    $display("FAIL zrun3_symbol: got sym=%b pos=%b neg=%b rds=%0d expected sym=%b pos=%b neg=%b rds=%0d at %0t",
                             sym3, pos3, neg3, $signed(rds3), e.sym, e.pos, e.neg, e.rds, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int cyc, input logic ami);
        mon_en  = 1'b0;
        mon3_en = 1'b0;
        @(negedge clk);
        data_valid = 1'b0;
        mode_ami   = ami;
        reset_n    = 1'b0;
        repeat (cyc) @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        q3.delete();
        last_rds = 0;
        mon_en = 1'b1;
    endtask

    task automatic send(input logic b);
        @(negedge clk);
        data_in    = b;
        data_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
    endtask

    // syms: one char per output ('0'..'3' = code); rails: '+', '-' or '0'.
    task automatic run_case(input string bits, input string syms, input string rails,
                            input int gap, input int flush, input int rmax,
                            input bit use3, input bit flip);
        int   acc = 0;
        byte  c;
        exp_t e;
        for (int i = 0; i < bits.len(); i++) begin
            if (i < syms.len()) begin
                c     = syms[i];
                e.sym = c[1:0];
                e.pos = (rails[i] == "+");
                e.neg = (rails[i] == "-");
                acc   = acc + (e.pos ? 1 : 0) - (e.neg ? 1 : 0);
                if (acc > rmax) acc = rmax;
                if (acc < -rmax) acc = -rmax;
                e.rds = acc;
                if (use3) q3.push_back(e);
                else q.push_back(e);
            end
            send(bits[i] == "1");
            if (flip && i == 1) mode_ami = 1'b1;
            if (gap > 0) idle(gap);
        end
        repeat (flush) send(1'b0);
        idle(4);
        checks++;
        if ((use3 ? q3.size() : q.size()) != 0) begin
            failures++;
            $display("FAIL drain: got %0d outputs still pending expected 0",
                     use3 ? q3.size() : q.size());
        end
    endtask

    task automatic test_reset;
        do_reset(2, 1'b0);
        checks += 2;
        if (sym_out !== 2'b00 || pos_out !== 1'b0 || neg_out !== 1'b0 ||
            out_valid !== 1'b0 || rds_out !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: got sym=%b pos=%b neg=%b ov=%b rds=%b expected all zero",
                     sym_out, pos_out, neg_out, out_valid, rds_out);
        end
        if (sym3 !== 2'b00 || pos3 !== 1'b0 || neg3 !== 1'b0 || ov3 !== 1'b0 || rds3 !== 2'd0) begin
            failures++;
            $display("FAIL reset_state_zrun3: got sym=%b pos=%b neg=%b ov=%b rds=%b expected all zero",
                     sym3, pos3, neg3, ov3, rds3);
        end
    endtask

    task automatic test_basic;
        do_reset(2, 1'b0);
        run_case("100001", "100021", "+000+-", 0, 4, 7, 1'b0, 1'b0);
    endtask

    task automatic test_b_substitution;
        do_reset(2, 1'b0);
        run_case("0000100000000", "0002100023002", "000-+000+-00-", 0, 4, 7, 1'b0, 1'b0);
    endtask

    task automatic test_ami;
        do_reset(2, 1'b1);
        run_case("0000000011", "0000000011", "00000000+-", 0, 4, 7, 1'b0, 1'b0);
    endtask

    task automatic test_gaps;
        do_reset(2, 1'b0);
        run_case("100001", "100021", "+000+-", 3, 4, 7, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midrun;
        do_reset(2, 1'b0);
        repeat (3) send(1'b0);
        do_reset(1, 1'b0);
        run_case("00000", "0002", "000-", 0, 4, 7, 1'b0, 1'b0);
    endtask

    task automatic test_mode_hold;
        do_reset(2, 1'b0);
        run_case("10000", "10002", "+000+", 0, 4, 7, 1'b0, 1'b1);
    endtask

    task automatic test_zrun3_saturation;
        do_reset(2, 1'b0);
        mon3_en = 1'b1;
        run_case("10001000", "10021002", "+00+-00-", 0, 3, 1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_b_substitution;
        test_ami;
        test_gaps;
        test_reset_midrun;
        test_mode_hold;
        test_zrun3_saturation;
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
